// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: register enables/flushes for load-use, branch flush and data-memory waits.
// Optional lost-cycle counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl #(
  parameter int TIMEOUT_W   = 8,
  parameter int MEM_TIMEOUT = 200,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mem_read,
  input  logic             ex_branch_taken,
  input  logic             mem_req,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             memwb_flush,
  output logic             mem_err,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_events
);

  // state    | meaning
  // RUN      | normal flow; hazards resolved combinationally
  // MEM_WAIT | data-memory access outstanding, pipeline frozen
  // ERR      | memory timeout; frozen until reset
  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    ERR      = 2'd2
  } state_t;

  localparam logic [TIMEOUT_W-1:0] WAIT_LAST = TIMEOUT_W'(MEM_TIMEOUT - 1);

  state_t               state;
  state_t               state_nxt;
  logic [TIMEOUT_W-1:0] wait_cnt;
  logic                 load_use;
  logic                 freeze;
  logic                 timeout_hit;

  assign load_use = ex_mem_read && (ex_rd != 5'd0) &&
                    ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                     (id_use_rs2 && (id_rs2 == ex_rd)));

  assign timeout_hit = (wait_cnt == WAIT_LAST);

  always_comb begin
    freeze = 1'b1;
    case (state)
      RUN:      freeze = mem_req && !mem_ready;
      MEM_WAIT: freeze = !mem_ready;
      default:  freeze = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) state <= RUN;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN: begin
        if (mem_req && !mem_ready) state_nxt = MEM_WAIT;
      end
      MEM_WAIT: begin
        if (mem_ready)        state_nxt = RUN;
        else if (timeout_hit) state_nxt = ERR;
      end
      default: state_nxt = ERR;
    endcase
  end

  // Release cycle of a wait falls through to branch/load-use using the held EX/ID contents.
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    idex_en     = 1'b1;
    exmem_en    = 1'b1;
    memwb_en    = 1'b1;
    ifid_flush  = 1'b0;
    idex_flush  = 1'b0;
    memwb_flush = 1'b0;
    busy        = (state == MEM_WAIT);
    if (!reset_n) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (freeze) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (ex_branch_taken) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Counter sits at 0 outside MEM_WAIT, so every wait starts from a cleared count.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wait_cnt <= '0;
    end else if (state != MEM_WAIT) begin
      wait_cnt <= '0;
    end else if (!mem_ready && !timeout_hit) begin
      wait_cnt <= wait_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      mem_err <= 1'b0;
    end else if ((state == MEM_WAIT) && !mem_ready && timeout_hit) begin
      mem_err <= 1'b1;
    end
  end

`ifdef PIPE_CTRL_PERF_EN
  logic             branch_flush;
  logic [CNT_W-1:0] stall_q;
  logic [CNT_W-1:0] flush_q;

  assign branch_flush = !freeze && ex_branch_taken;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (!pc_en && (stall_q != {CNT_W{1'b1}}))       stall_q <= stall_q + 1'b1;
      if (branch_flush && (flush_q != {CNT_W{1'b1}})) flush_q <= flush_q + 1'b1;
    end
  end

  assign stall_cycles = stall_q;
  assign flush_events = flush_q;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Randomized bench for pipe_ctrl: stimulus pushes model predictions, a negedge monitor pops and compares.
module tb_pipe_ctrl;
  localparam int TW   = 8;
  localparam int TOUT = 4;
  localparam int CW   = 6;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic [4:0] id_rs1 = '0, id_rs2 = '0, ex_rd = '0;
  logic id_use_rs1 = 1'b0, id_use_rs2 = 1'b0;
  logic ex_mem_read = 1'b0, ex_branch_taken = 1'b0;
  logic mem_req = 1'b0, mem_ready = 1'b0;
  logic pc_en, ifid_en, idex_en, exmem_en, memwb_en;
  logic ifid_flush, idex_flush, memwb_flush, mem_err, busy;
  logic [CW-1:0] stall_cycles, flush_events;

  always #5 clk = ~clk;

  pipe_ctrl #(.TIMEOUT_W(TW), .MEM_TIMEOUT(TOUT), .CNT_W(CW)) dut (
    .clk(clk), .reset_n(reset_n),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
    .ex_rd(ex_rd), .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
    .mem_req(mem_req), .mem_ready(mem_ready),
    .pc_en(pc_en), .ifid_en(ifid_en), .idex_en(idex_en), .exmem_en(exmem_en), .memwb_en(memwb_en),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .memwb_flush(memwb_flush),
    .mem_err(mem_err), .busy(busy), .stall_cycles(stall_cycles), .flush_events(flush_events)
  );

  typedef struct packed {
    logic [4:0]    en;   // pc, ifid, idex, exmem, memwb
    logic [2:0]    fl;   // ifid, idex, memwb
    logic          err;
    logic          busy;
    logic [CW-1:0] stall;
    logic [CW-1:0] flc;
  } obs_t;

  obs_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;

  // Reference model: pipeline "waiting" on memory, "dead" after timeout, count of unanswered wait cycles.
  bit waiting = 0;
  bit dead = 0;
  int waits = 0;
  int stall_m = 0;
  int flush_m = 0;

  task automatic step(input logic rn, input logic req, input logic rdy, input logic br,
                      input logic mr, input logic [4:0] rd, input logic [4:0] rs1,
                      input logic [4:0] rs2, input logic u1, input logic u2);
    obs_t e;
    bit   frozen, hazard, stalled, flushed;
    @(posedge clk);
    #1;
    reset_n = rn; mem_req = req; mem_ready = rdy; ex_branch_taken = br;
    ex_mem_read = mr; ex_rd = rd; id_rs1 = rs1; id_rs2 = rs2; id_use_rs1 = u1; id_use_rs2 = u2;
    cyc++;

    hazard  = mr && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
    frozen  = dead || (waiting ? !rdy : (req && !rdy));
    stalled = 0;
    flushed = 0;
    e.err   = dead;
    e.busy  = waiting;
    e.stall = CW'(stall_m);
    e.flc   = CW'(flush_m);
    if (!rn) begin
      e.en = 5'b00000; e.fl = 3'b111;
    end else if (frozen) begin
      e.en = 5'b00000; e.fl = 3'b001; stalled = 1;
    end else if (br) begin
      e.en = 5'b11111; e.fl = 3'b110; flushed = 1;
    end else if (hazard) begin
      e.en = 5'b00111; e.fl = 3'b010; stalled = 1;
    end else begin
      e.en = 5'b11111; e.fl = 3'b000;
    end
    sb.push_back(e);

    if (!rn) begin
      waiting = 0; dead = 0; waits = 0; stall_m = 0; flush_m = 0;
    end else begin
`ifdef PIPE_CTRL_PERF_EN
      if (stalled && stall_m < CMAX) stall_m++;
      if (flushed && flush_m < CMAX) flush_m++;
`endif
      if (dead) begin
      end else if (waiting) begin
        if (rdy) waiting = 0;
        else begin
          waits++;
          if (waits == TOUT) begin dead = 1; waiting = 0; end
        end
      end else if (req && !rdy) begin
        waiting = 1; waits = 0;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
  endtask

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        a = '{en: {pc_en, ifid_en, idex_en, exmem_en, memwb_en},
              fl: {ifid_flush, idex_flush, memwb_flush},
              err: mem_err, busy: busy, stall: stall_cycles, flc: flush_events};
        n_cmp++;
        if (a !== e) begin
          n_bad++;
          $display("FAIL outputs cyc=%0d: got en=%b fl=%b err=%b busy=%b stall=%0d flush=%0d, want en=%b fl=%b err=%b busy=%b stall=%0d flush=%0d",
                   cyc, a.en, a.fl, a.err, a.busy, a.stall, a.flc,
                   e.en, e.fl, e.err, e.busy, e.stall, e.flc);
        end
      end
    end
  end

  initial begin : stimulus
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 1, 0, 1, 1, 5'd5, 5'd5, 5'd5, 1, 1);
    idle(2);
    // load-use on rs1, then clear
    step(1, 0, 0, 0, 1, 5'd5, 5'd5, 5'd9, 1, 0);
    idle(1);
    // load-use via rs2 only
    step(1, 0, 0, 0, 1, 5'd7, 5'd1, 5'd7, 0, 1);
    // x0 never hazards; unused source never hazards
    step(1, 0, 0, 0, 1, 5'd0, 5'd0, 5'd0, 1, 1);
    step(1, 0, 0, 0, 1, 5'd6, 5'd6, 5'd6, 0, 0);
    // branch squashes a concurrent load-use
    step(1, 0, 0, 1, 1, 5'd5, 5'd5, 5'd0, 1, 0);
    // mem_ready without mem_req is ignored
    step(1, 0, 1, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    // three-cycle memory wait, release with a branch pending
    step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(1, 1, 1, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);
    // wait released into a load-use
    step(1, 1, 0, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
    step(1, 1, 1, 0, 1, 5'd3, 5'd3, 5'd0, 1, 0);
    idle(1);
    // timeout: ready never arrives, then one reset cycle
    for (int i = 0; i < 8; i++) step(1, 1, 0, 1, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);
    // reset mid-wait
    step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    idle(2);
    // long ERR residency drives the stall counter into saturation
    for (int i = 0; i < 80; i++) step(1, 1, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    step(0, 0, 0, 0, 0, 5'd0, 5'd0, 5'd0, 0, 0);
    // random traffic, registers drawn from x0..x3 to make matches frequent
    for (int i = 0; i < 3000; i++) begin
      step(logic'($urandom_range(0, 149) != 0),
           logic'($urandom_range(0, 3) == 0),
           logic'($urandom_range(0, 2) == 0),
           logic'($urandom_range(0, 5) == 0),
           logic'($urandom_range(0, 1)),
           5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
           logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)));
    end
    repeat (2) @(negedge clk);
    #1;
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
